// File: rtl/l2_arb_pkg.sv
// ----------------------------------------------------------------------------
// l2_arb_pkg
//   Types and widths shared between the L1->L2 request arbiter and the L2
//   datapath.
//   S_ADDR      : request address width
//   S_LINE      : cache line width (equals the L2 line width)
//   S_OFFSET    : line offset bits, zeroed on the address sent to L2
//   OFFSET_MASK : mask covering the line offset bits
//   arb_state_t : arbiter FSM states
//   port_t      : requester identity (I-cache / D-cache)
//   l2_req_t    : latched copy of the winning request
// ----------------------------------------------------------------------------
package l2_arb_pkg;

    localparam int S_ADDR   = 32;
    localparam int S_LINE   = 256;
    localparam int S_OFFSET = 5;

    localparam logic [S_ADDR-1:0] OFFSET_MASK = S_ADDR'((1 << S_OFFSET) - 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

    typedef struct packed {
        logic              write;
        logic [S_ADDR-1:0] addr;
        logic [S_LINE-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/l2_arbiter.sv
// ----------------------------------------------------------------------------
// l2_arbiter
//   Round-robin arbiter between the L1 I-cache (line reads) and the L1
//   D-cache (line reads / write-backs) in front of the L2. One request is
//   served at a time; the winning request is latched and drives the L2
//   mem_* interface from flops, and the L2 response is routed back to the
//   granted requester as a one-cycle *_pmem_resp pulse.
//
//   clk, rst                : clock, asynchronous active-high reset
//   i_pmem_read/address     : I-cache request (level)
//   i_pmem_rdata/resp       : I-cache returned line / completion pulse
//   d_pmem_read/write       : D-cache request (level), write wins if both
//   d_pmem_address/wdata    : D-cache request address / write line
//   d_pmem_rdata/resp       : D-cache returned line / completion pulse
//   l2_mem_read/write       : request strobes to L2, held until l2_mem_resp
//   l2_mem_address/wdata    : latched line address (offset zeroed) / data
//   l2_mem_rdata/resp       : L2 read line / completion pulse
// ----------------------------------------------------------------------------
module l2_arbiter
    import l2_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [S_ADDR-1:0] i_pmem_address,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [S_ADDR-1:0] d_pmem_address,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              l2_mem_read,
    output logic              l2_mem_write,
    output logic [S_ADDR-1:0] l2_mem_address,
    output logic [S_LINE-1:0] l2_mem_wdata,
    input  logic [S_LINE-1:0] l2_mem_rdata,
    input  logic              l2_mem_resp
);

    arb_state_t        state_q, state_d;
    port_t             last_grant_q, last_grant_d;
    l2_req_t           req_q, req_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic [S_LINE-1:0] i_rdata_q, i_rdata_d;
    logic [S_LINE-1:0] d_rdata_q, d_rdata_d;

    logic              i_req, d_req;
    logic              grant_i, grant_d;

    // Round-robin pick: a lone requester wins; on a tie the port that was
    // not granted last wins.
    always_comb begin
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = i_req & (~d_req | (last_grant_q == PORT_D));
        grant_d = d_req & ~grant_i;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    // I-side grants leave the latched wdata alone; only the
                    // D-cache supplies write data.
                    req_d.write  = 1'b0;
                    req_d.addr   = i_pmem_address;
                    l2_read_d    = 1'b1;
                    l2_write_d   = 1'b0;
                    last_grant_d = PORT_I;
                    state_d      = BUSY_I;
                end else if (grant_d) begin
                    req_d.write  = d_pmem_write;
                    req_d.addr   = d_pmem_address;
                    req_d.wdata  = d_pmem_wdata;
                    l2_read_d    = ~d_pmem_write;
                    l2_write_d   = d_pmem_write;
                    last_grant_d = PORT_D;
                    state_d      = BUSY_D;
                end
            end

            BUSY_I: begin
                if (l2_mem_resp) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    i_rdata_d  = l2_mem_rdata;
                    i_resp_d   = 1'b1;
                    state_d    = RESP_I;
                end
            end

            BUSY_D: begin
                if (l2_mem_resp) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    // A write-back leaves the D-side read line untouched.
                    if (!req_q.write) begin
                        d_rdata_d = l2_mem_rdata;
                    end
                    d_resp_d   = 1'b1;
                    state_d    = RESP_D;
                end
            end

            // The response cycle never samples requests, so a requester
            // still holding its level for one cycle is not re-granted.
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            req_q        <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign l2_mem_read    = l2_read_q;
    assign l2_mem_write   = l2_write_q;
    assign l2_mem_address = req_q.addr & ~OFFSET_MASK;
    assign l2_mem_wdata   = req_q.wdata;
    assign i_pmem_rdata   = i_rdata_q;
    assign i_pmem_resp    = i_resp_q;
    assign d_pmem_rdata   = d_rdata_q;
    assign d_pmem_resp    = d_resp_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_arbiter
//   Scoreboard bench for l2_arbiter. Requester tasks push the expected
//   response line when they issue; independent monitors pop and compare on
//   every *_pmem_resp and check every L2 access against the request that
//   owns it. A behavioural L2 with configurable latency sits on mem_*.
//   I-cache traffic lives below 0x8000_0000 and D-cache traffic above, so
//   the address of an L2 access identifies the granted port.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_arbiter;
    import l2_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read;
    logic [31:0]       i_pmem_address;
    logic [255:0]      i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [31:0]       d_pmem_address;
    logic [255:0]      d_pmem_wdata;
    logic [255:0]      d_pmem_rdata;
    logic              d_pmem_resp;
    logic              l2_mem_read;
    logic              l2_mem_write;
    logic [31:0]       l2_mem_address;
    logic [255:0]      l2_mem_wdata;
    logic [255:0]      l2_mem_rdata;
    logic              l2_mem_resp;

    l2_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .l2_mem_read    (l2_mem_read),
        .l2_mem_write   (l2_mem_write),
        .l2_mem_address (l2_mem_address),
        .l2_mem_wdata   (l2_mem_wdata),
        .l2_mem_rdata   (l2_mem_rdata),
        .l2_mem_resp    (l2_mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_w(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [255:0] ref_mem [logic [31:0]];  // what memory should hold
    logic [255:0] l2m     [logic [31:0]];  // what the L2 actually received
    logic [255:0] d_rdata_model;           // expected D-side rdata register
    logic [255:0] exp_i_q[$];
    logic [255:0] exp_d_q[$];
    int           grant_log[$];            // 0 = I, 1 = D, in L2 access order

    function automatic logic [255:0] init_line(input logic [31:0] a);
        return {8{a ^ 32'hC3C3_5A5A}};
    endfunction

    function automatic logic [255:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic logic [31:0] rand_i_addr();
        return 32'($urandom_range(0, 32'h3FFF));
    endfunction

    function automatic logic [31:0] rand_d_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
    endfunction

    // Current outstanding request per port, as issued by the bench.
    logic [31:0]  cur_i_addr;
    logic [31:0]  cur_d_addr;
    logic         cur_d_write;
    logic [255:0] cur_d_wdata;

    int           i_issue_cyc, start_cyc, l2_resp_cyc, i_resp_cyc, d_resp_cyc;
    logic [31:0]  start_addr;

    // ---------------- behavioural L2 ----------------
    int l2_lat   = 3;
    bit l2_rand  = 1'b0;
    bit spurious = 1'b0;

    initial begin
        bit active;
        int cnt;
        active = 1'b0;
        cnt = 0;
        l2_mem_resp  = 1'b0;
        l2_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            l2_mem_resp = 1'b0;
            if (rst) begin
                active = 1'b0;
            end else if (active) begin
                cnt--;
                if (cnt == 0) begin
                    active      = 1'b0;
                    l2_mem_resp = 1'b1;
                    l2_resp_cyc = cyc;
                    if (l2_mem_write) begin
                        l2m[l2_mem_address] = l2_mem_wdata;
                        l2_mem_rdata = {8{$urandom}};
                    end else begin
                        l2_mem_rdata = l2m.exists(l2_mem_address) ? l2m[l2_mem_address]
                                                                  : init_line(l2_mem_address);
                    end
                end
            end else if (l2_mem_read || l2_mem_write) begin
                active = 1'b1;
                cnt    = l2_rand ? $urandom_range(1, 4) : l2_lat;
            end else if (spurious && $urandom_range(0, 7) == 0) begin
                // Stray completion while the arbiter is not waiting on L2.
                l2_mem_resp  = 1'b1;
                l2_mem_rdata = {8{$urandom}};
            end
        end
    end

    // ---------------- L2 access monitor ----------------
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (l2_mem_read || l2_mem_write)) begin
                if (!prev) begin
                    start_cyc  = cyc;
                    start_addr = l2_mem_address;
                    if (!l2_mem_address[31]) begin
                        grant_log.push_back(0);
                        check("i_l2_op", 32'({l2_mem_read, l2_mem_write}), 32'd2);
                        check("i_l2_addr", l2_mem_address, cur_i_addr & ~32'h1F);
                    end else begin
                        grant_log.push_back(1);
                        check("d_l2_op", 32'({l2_mem_read, l2_mem_write}), cur_d_write ? 32'd1 : 32'd2);
                        check("d_l2_addr", l2_mem_address, cur_d_addr & ~32'h1F);
                        if (cur_d_write) check_w("d_l2_wdata", l2_mem_wdata, cur_d_wdata);
                    end
                end else begin
                    check("l2_addr_stable", l2_mem_address, start_addr);
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        bit ip, dp;
        ip = 1'b0;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (ip) check("i_resp_width", 32'(i_pmem_resp), 32'd0);
            if (dp) check("d_resp_width", 32'(d_pmem_resp), 32'd0);
            if (i_pmem_resp && !ip) begin
                i_resp_cyc = cyc;
                check("i_resp_expected", 32'(exp_i_q.size() != 0), 32'd1);
                if (exp_i_q.size() != 0) check_w("i_rdata", i_pmem_rdata, exp_i_q.pop_front());
            end
            if (d_pmem_resp && !dp) begin
                d_resp_cyc = cyc;
                check("d_resp_expected", 32'(exp_d_q.size() != 0), 32'd1);
                if (exp_d_q.size() != 0) check_w("d_rdata", d_pmem_rdata, exp_d_q.pop_front());
            end
            ip = i_pmem_resp;
            dp = d_pmem_resp;
        end
    end

    // ---------------- requester drivers ----------------
    task automatic do_i_read(input logic [31:0] a);
        bit got;
        @(posedge clk); #1;
        cur_i_addr     = a;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        i_issue_cyc    = cyc;
        exp_i_q.push_back(ref_rd(a & ~32'h1F));
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (i_pmem_resp) got = 1'b1;
        end
        i_pmem_read = 1'b0;
        check("i_resp_timeout", 32'(got), 32'd1);
        if (!got) exp_i_q.delete();
    endtask

    task automatic do_d(input bit wr, input logic [31:0] a, input logic [255:0] wd, input bit wiggle);
        bit got;
        @(posedge clk); #1;
        cur_d_addr     = a;
        cur_d_write    = wr;
        cur_d_wdata    = wd;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_write   = wr;
        d_pmem_read    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wr) ref_mem[a & ~32'h1F] = wd;
        else    d_rdata_model = ref_rd(a & ~32'h1F);
        exp_d_q.push_back(d_rdata_model);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (d_pmem_resp) got = 1'b1;
            else if (wiggle && (l2_mem_read || l2_mem_write)) d_pmem_address = a ^ 32'h0000_0FE0;
        end
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = a;
        check("d_resp_timeout", 32'(got), 32'd1);
        if (!got) exp_d_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 32'({l2_mem_read, l2_mem_write, i_pmem_resp, d_pmem_resp}), 32'd0);
        check({tag, "_addr"}, l2_mem_address, 32'd0);
        check_w({tag, "_wdata"}, l2_mem_wdata, '0);
        check_w({tag, "_i_rdata"}, i_pmem_rdata, '0);
        check_w({tag, "_d_rdata"}, d_pmem_rdata, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d_rdata_model = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int i1, d1;
        bit got;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        d_rdata_model  = '0;
        cur_i_addr     = '0;
        cur_d_addr     = '0;
        cur_d_write    = 1'b0;
        cur_d_wdata    = '0;
        ref_mem[32'h0000_1220] = {8{32'hDEADBEEF}};
        l2m[32'h0000_1220]     = {8{32'hDEADBEEF}};

        repeat (3) @(negedge clk);
        check_zero("init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // I read alone, fixed latency 3
        l2_lat = 3;
        do_i_read(32'h0000_1234);
        check("i_addr_aligned", start_addr, 32'h0000_1220);
        check("grant_latency", 32'(start_cyc), 32'(i_issue_cyc + 1));
        check("resp_latency", 32'(i_resp_cyc), 32'(l2_resp_cyc + 1));
        check_w("i_rdata_hold", i_pmem_rdata, {8{32'hDEADBEEF}});

        // D write-back, then read it back
        do_d(1'b1, 32'h8000_0040, {8{32'hA5A5A5A5}}, 1'b0);
        check_w("d_rdata_after_wb", d_pmem_rdata, d_rdata_model);
        do_d(1'b0, 32'h8000_0040, '0, 1'b0);
        check_w("d_readback", d_pmem_rdata, {8{32'hA5A5A5A5}});

        // Simultaneous requests after reset, then continuous contention
        do_reset();
        l2_lat = 2;
        grant_log.delete();
        fork
            begin
                do_i_read(rand_i_addr());
                i1 = i_resp_cyc;
                repeat (3) do_i_read(rand_i_addr());
            end
            begin
                do_d(1'($urandom_range(0, 1)), rand_d_addr(), {8{$urandom}}, 1'b0);
                d1 = d_resp_cyc;
                repeat (3) do_d(1'($urandom_range(0, 1)), rand_d_addr(), {8{$urandom}}, 1'b0);
            end
        join
        check("tie_separation", 32'((d1 - i1) >= l2_lat + 2), 32'd1);
        check("grant_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < grant_log.size() && k < 8; k++)
            check($sformatf("grant_order[%0d]", k), 32'(grant_log[k]), 32'(k % 2));

        // Reset while BUSY_D: outputs clear at once, no D response
        l2_lat = 8;
        @(posedge clk); #1;
        cur_d_addr     = 32'h8000_0100;
        cur_d_write    = 1'b1;
        cur_d_wdata    = {8{32'h1357_9BDF}};
        d_pmem_address = cur_d_addr;
        d_pmem_wdata   = cur_d_wdata;
        d_pmem_write   = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (l2_mem_write) got = 1'b1;
        end
        check("midrst_busy", 32'(got), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        d_pmem_write = 1'b0;
        d_pmem_read  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d_rdata_model = '0;
        repeat (12) @(negedge clk);
        l2_lat = 3;
        do_i_read(32'h0000_1234);
        check_w("post_rst_i_rdata", i_pmem_rdata, {8{32'hDEADBEEF}});

        // Requester address changes while BUSY_D
        do_d(1'b0, 32'h8000_0200, '0, 1'b1);
        do_d(1'b1, 32'h8000_0220, {8{$urandom}}, 1'b1);
        do_d(1'b0, 32'h8000_0220, '0, 1'b0);

        // Random traffic, random latency, stray L2 completions
        l2_rand  = 1'b1;
        spurious = 1'b1;
        fork
            repeat (20) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_i_read(rand_i_addr());
            end
            repeat (20) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_d(1'($urandom_range(0, 1)), rand_d_addr(), {8{$urandom}}, 1'b0);
            end
        join
        spurious = 1'b0;
        repeat (5) @(negedge clk);
        check("exp_i_drained", 32'(exp_i_q.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port request arbiter directly upstream of the L2 cache datapath. It accepts 256-bit line requests from the L1 instruction cache (read only) and the L1 data cache (read or write-back), and grants one at a time using round-robin priority. It drives the L2 `mem_*` interface from registered copies of the winning request and returns the response to the requester that was granted.

## Interface
- `S_ADDR`, 32: address width.
- `S_LINE`, 256: line width (must equal L2 line width).
- `S_OFFSET`, 5: line offset bits, forced to zero toward L2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `i_pmem_read`  in  1: I-cache line read request, level.
- `i_pmem_address`  in  S_ADDR: I-cache request address.
- `i_pmem_rdata`  out  S_LINE: line returned to the I-cache.
- `i_pmem_resp`  out  1: one-cycle completion pulse to the I-cache.
- `d_pmem_read`  in  1: D-cache line read request, level.
- `d_pmem_write`  in  1: D-cache line write-back request, level.
- `d_pmem_address`  in  S_ADDR: D-cache request address.
- `d_pmem_wdata`  in  S_LINE: D-cache write line.
- `d_pmem_rdata`  out  S_LINE: line returned to the D-cache.
- `d_pmem_resp`  out  1: one-cycle completion pulse to the D-cache.
- `l2_mem_read`  out  1: read request to L2.
- `l2_mem_write`  out  1: write request to L2.
- `l2_mem_address`  out  S_ADDR: `{latched[31:5], 5'b0}`.
- `l2_mem_wdata`  out  S_LINE: latched D-cache write data.
- `l2_mem_rdata`  in  S_LINE: L2 read line.
- `l2_mem_resp`  in  1: L2 completion pulse.

## Operation
- **Requester protocol:** each requester holds read/write and address/wdata stable until it sees its `*_resp`, then drops the request no later than the cycle after the pulse.
- **States** (`arb_state_t`): IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- **IDLE:**
  - Samples `i_req = i_pmem_read` and `d_req = d_pmem_read | d_pmem_write`.
  - Neither request present: stays in IDLE.
  - One request present: grants it.
  - Both present: grants the port opposite `last_grant`.
  - On a grant, latches address, wdata and op (write wins if the D-cache asserts both read and write), updates `last_grant`, and goes to BUSY_x.
- **BUSY_x:**
  - Drives `l2_mem_read`/`l2_mem_write` from the latched op, holding them high until `l2_mem_resp`.
  - On `l2_mem_resp`: captures `l2_mem_rdata` into the granted port's rdata register (reads only), then goes to RESP_x.
  - Requester inputs are ignored while in BUSY_x.
- **RESP_x:**
  - Asserts `x_pmem_resp` for exactly one cycle.
  - L2 request lines are low.
  - Next state is IDLE unconditionally.
  - Requests are not sampled in RESP_x, so a just-served requester cannot be re-granted on a stale level.
- **rdata registers:** each port's `*_pmem_rdata` holds its value until that port's next read capture. A write does not change it.

## Timing
- **Reset (async, immediate):**
  - State = IDLE, `last_grant` = D (the first tie goes to I).
  - All outputs are 0, including both rdata registers and the latched address/wdata.
- **Reset mid-transaction:** the in-flight L2 access is abandoned and no `*_resp` is issued. L2 is reset on the same `rst`.
- **Grant latency:** a request present at the IDLE edge k produces `l2_mem_read`/`l2_mem_write` high in cycle k+1. All L2-side outputs are registered.
- **Response latency:** `l2_mem_resp` at edge m produces `x_pmem_resp` high and rdata valid in cycle m+1.
- **Minimum turnaround:** one L2 access per (L2 latency + 2) cycles.
- **Starvation bound:** under continuous contention, grants strictly alternate I, D, I, D.
- **Ignored input:** `l2_mem_resp` arriving in IDLE or RESP_x is ignored.

## Structure
- Package `l2_arb_pkg`:
  - `arb_state_t` enum.
  - `port_t` enum {PORT_I, PORT_D}.
  - Width localparams shared with the L2 (`S_LINE`, `S_OFFSET`).
- Single module; no sub-module. The round-robin pick is a few gates in the next-state logic.

## Test plan
- **I read alone:** I reads 0x0000_1234 while L2 responds 3 cycles after `l2_mem_read` with line `{8{32'hDEADBEEF}}` -> `l2_mem_address` = 0x0000_1220; `i_pmem_resp` pulses one cycle later with that line; `d_pmem_resp` stays 0.
- **D write-back:** D writes to 0x8000_0040 with wdata = `{8{32'hA5A5A5A5}}` -> `l2_mem_write` = 1 and `l2_mem_wdata` matches; `d_pmem_resp` pulses once; `d_pmem_rdata` is unchanged.
- **Simultaneous requests after reset:** I and D both request after reset -> I is served first, D second; the two `*_resp` pulses are separated by at least L2 latency + 2 cycles.
- **Continuous contention:** both ports re-request immediately after each response for 8 transactions -> grant order is I, D, I, D, I, D, I, D.
- **Reset mid-transaction:** `rst` pulses while in BUSY_D -> all outputs go to 0 asynchronously; no `d_pmem_resp` is issued; a new I request afterward completes normally.
- **Input stability:** `d_pmem_address` changes during BUSY_D -> `l2_mem_address` keeps the latched value until RESP_D.
